// File: rtl/mctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction-field constants and the ALU operation codes consumed by the
// datapath.
package mctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // IR[5:0] for R-type
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_ADD = 6'b100000;

  // alucntrl encoding
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;

endpackage

// File: rtl/mctrl_alu_decode.sv
// Combinational instruction decoder: maps (opcode, funct) to the ALU
// operation and datapath mux selects, and flags unsupported encodings.
module mctrl_alu_decode
  import mctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alucntrl,
  output logic       alu_src,
  output logic       immsel,
  output logic       legal
);

  // Opcode/funct table lookup; unsupported encodings decode to all-zero controls.
  always_comb begin
    alucntrl = ALU_AND;
    alu_src  = 1'b0;
    immsel   = 1'b0;
    legal    = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_AND: alucntrl = ALU_AND;
          FN_OR:  alucntrl = ALU_OR;
          FN_SLL: begin
            alucntrl = ALU_SLL;
            alu_src  = 1'b1;
          end
          FN_SRL: begin
            alucntrl = ALU_SRL;
            alu_src  = 1'b1;
          end
          FN_SUB: alucntrl = ALU_SUB;
          FN_ADD: alucntrl = ALU_ADD;
          default: legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alucntrl = ALU_ADD;
        alu_src  = 1'b1;
        immsel   = 1'b1;
        legal    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: sequences FETCH/DECODE/EXEC/MEM/WB with a
// ready handshake on every memory access and counts retired instructions.
// Optional feature macro: MCTRL_MEM_TIMEOUT_EN (bounded memory wait, sticky
// fault flag, HALT state left only by reset).
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             regWrite,
  output logic [2:0]       alucntrl,
  output logic             ALUsrc,
  output logic             memtoreg,
  output logic             immsel,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     next_state;

  logic [2:0] dec_alu;
  logic       dec_src;
  logic       dec_imm;
  logic       dec_legal;
  logic       is_lw;
  logic       is_sw;
  logic       is_mem_op;
  logic       retire;
  logic       timeout;

  mctrl_alu_decode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alucntrl (dec_alu),
    .alu_src  (dec_src),
    .immsel   (dec_imm),
    .legal    (dec_legal)
  );

  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_mem_op = is_lw || is_sw;

`ifdef MCTRL_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q;
  logic              waiting;

  assign waiting = (state == ST_FETCH) || (state == ST_MEM);
  assign timeout = waiting && !mem_ready &&
                   (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign fault   = fault_q;

  // Wait counter: zero on any state change, counts while a wait state holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!waiting || (next_state != state)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (timeout) begin
      fault_q <= 1'b1;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   next_state = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    next_state = ST_DECODE;
        else if (timeout) next_state = ST_HALT;
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        if (!dec_legal)     next_state = ST_FETCH;
        else if (is_mem_op) next_state = ST_MEM;
        else                next_state = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)    next_state = is_sw ? ST_FETCH : ST_WB;
        else if (timeout) next_state = ST_HALT;
      end
      ST_WB:     next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output decode from state and the held instruction fields.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    regWrite  = 1'b0;
    alucntrl  = ALU_AND;
    ALUsrc    = 1'b0;
    memtoreg  = 1'b0;
    immsel    = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXEC: begin
        alucntrl = dec_alu;
        ALUsrc   = dec_src;
        immsel   = dec_imm;
        illegal  = !dec_legal;
      end
      ST_MEM: begin
        alucntrl  = dec_alu;
        ALUsrc    = dec_src;
        immsel    = dec_imm;
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      ST_WB: begin
        alucntrl = dec_alu;
        ALUsrc   = dec_src;
        immsel   = dec_imm;
        regWrite = 1'b1;
        memtoreg = is_lw;
      end
      default: ;
    endcase
  end

  // An instruction retires on the WB cycle or on SW completion in MEM.
  assign retire = (state == ST_WB) || ((state == ST_MEM) && mem_ready && is_sw);

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process schedules each
// instruction from the documented cycle timeline and pushes the expected
// per-cycle outputs; the monitor pops and compares one entry per cycle.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;
`ifdef MCTRL_MEM_TIMEOUT_EN
  localparam int unsigned MAXW = TO - 1;
`else
  localparam int unsigned MAXW = 6;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          mem_ready;
  logic          pc_write, ir_write, mem_read, mem_write, regWrite;
  logic [2:0]    alucntrl;
  logic          ALUsrc, memtoreg, immsel, illegal, fault;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .regWrite  (regWrite),
    .alucntrl  (alucntrl),
    .ALUsrc    (ALUsrc),
    .memtoreg  (memtoreg),
    .immsel    (immsel),
    .illegal   (illegal),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pc_write;
    logic          ir_write;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          illegal;
    logic          memtoreg;
    logic [2:0]    alu;
    logic          alusrc;
    logic          immsel;
    logic          fault;
    logic [CW-1:0] retired;
  } obs_t;

  typedef struct {
    obs_t        v;
    obs_t        m;
    int unsigned cyc;
  } exp_t;

  exp_t          sb[$];
  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  int unsigned   cycle_no = 0;
  logic [CW-1:0] count;
  logic          fault_m;

  // Instruction kinds: 0 R-type, 1 LW, 2 SW, 3 ADDI, 4 unsupported opcode.
  task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                          output int kind, output logic [2:0] alu,
                          output logic src, output logic imm, output logic legal);
    kind = 4; alu = 3'b000; src = 1'b0; imm = 1'b0; legal = 1'b1;
    case (op)
      6'b000000: begin
        kind = 0;
        case (fn)
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b000000: begin alu = 3'b010; src = 1'b1; end
          6'b000010: begin alu = 3'b011; src = 1'b1; end
          6'b100010: alu = 3'b100;
          6'b100000: alu = 3'b101;
          default:   legal = 1'b0;
        endcase
      end
      6'b100011: begin kind = 1; alu = 3'b101; src = 1'b1; imm = 1'b1; end
      6'b101011: begin kind = 2; alu = 3'b101; src = 1'b1; imm = 1'b1; end
      6'b001000: begin kind = 3; alu = 3'b101; src = 1'b1; imm = 1'b1; end
      default:   legal = 1'b0;
    endcase
  endtask

  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.retired = count;
    o.fault   = fault_m;
    return o;
  endfunction

  function automatic obs_t sel(input logic [2:0] alu, input logic src, input logic imm);
    obs_t o;
    o = base();
    o.alu    = alu;
    o.alusrc = src;
    o.immsel = imm;
    return o;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle's inputs, record what the outputs must be, advance.
  task automatic drive_cycle(input logic rdy, input logic rst, input obs_t v, input obs_t m);
    exp_t e;
    reset     = rst;
    mem_ready = rdy;
    e.v = v; e.m = m; e.cyc = cycle_no;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic post_reset();
    drive_cycle(rnd_bit(), 1'b0, base(), '1);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned fw, input int unsigned mw,
                           input int abort_mem);
    int         kind;
    logic [2:0] alu;
    logic       src, imm, legal;
    obs_t       v, m, nosel;
    classify(op, fn, kind, alu, src, imm, legal);
    nosel = '1;
    nosel.alu = '0; nosel.alusrc = 1'b0; nosel.immsel = 1'b0;
    for (int unsigned i = 0; i <= fw; i++) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      v = base();
      v.mem_read = 1'b1;
      v.ir_write = (i == fw);
      v.pc_write = (i == fw);
      drive_cycle(i == fw, 1'b0, v, '1);
    end
    opcode = op;
    funct  = fn;
    drive_cycle(rnd_bit(), 1'b0, base(), nosel);
    if (!legal) begin
      v = base();
      v.illegal = 1'b1;
      drive_cycle(rnd_bit(), 1'b0, v, nosel);
      return;
    end
    drive_cycle(rnd_bit(), 1'b0, sel(alu, src, imm), '1);
    if (kind == 1 || kind == 2) begin
      for (int unsigned i = 0; i <= mw; i++) begin
        v = sel(alu, src, imm);
        v.mem_read  = (kind == 1);
        v.mem_write = (kind == 2);
        if (int'(i) == abort_mem) begin
          drive_cycle(1'b0, 1'b1, v, '1);
          count   = '0;
          fault_m = 1'b0;
          post_reset();
          return;
        end
        drive_cycle(i == mw, 1'b0, v, '1);
      end
      if (kind == 2) begin
        count = count + 1'b1;
        return;
      end
    end
    v = sel(alu, src, imm);
    v.reg_write = 1'b1;
    v.memtoreg  = (kind == 1);
    drive_cycle(rnd_bit(), 1'b0, v, '1);
    count = count + 1'b1;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    obs_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = '{pc_write, ir_write, mem_read, mem_write, regWrite, illegal,
                memtoreg, alucntrl, ALUsrc, immsel, fault, retired};
        vectors++;
        if (((act ^ e.v) & e.m) !== '0) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: got %h expected %h (care %h)",
                   e.cyc, act, e.v, e.m);
        end
      end
    end
  end

  // Stimulus: reset, directed instructions, then randomized traffic.
  initial begin
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    int unsigned fw, mw;
    int abort_mem;
    fns = '{6'b100100, 6'b100101, 6'b000000, 6'b000010, 6'b100010, 6'b100000};
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
    count = '0; fault_m = 1'b0;
    @(posedge clk);
    #1;
    drive_cycle(1'b0, 1'b1, base(), '1);
    post_reset();

    run_instr(6'b000000, 6'b100000, 0, 0, -1);  // ADD
    run_instr(6'b100011, 6'b010101, 0, 3, -1);  // LW, 3 wait states
    run_instr(6'b101011, 6'b000000, 1, 0, -1);  // SW
    run_instr(6'b111111, 6'b100000, 0, 0, -1);  // bad opcode
    run_instr(6'b000000, 6'b000111, 0, 0, -1);  // bad funct
    run_instr(6'b001000, 6'b111111, 2, 0, -1);  // ADDI
    run_instr(6'b000000, 6'b000000, 0, 0, -1);  // SLL
    run_instr(6'b000000, 6'b000010, 0, 0, -1);  // SRL
    run_instr(6'b100011, 6'b000000, 0, 3, 2);   // LW aborted by reset in MEM

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin op = 6'b000000; fn = fns[$urandom_range(0, 5)]; end
        4:          begin op = 6'b000000; fn = 6'($urandom); end
        5, 9:       begin op = 6'b100011; fn = 6'($urandom); end
        6:          begin op = 6'b101011; fn = 6'($urandom); end
        7:          begin op = 6'b001000; fn = 6'($urandom); end
        default:    begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      fw = $urandom_range(0, MAXW);
      mw = $urandom_range(0, MAXW);
      abort_mem = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, mw)) : -1;
      run_instr(op, fn, fw, mw, abort_mem);
    end

`ifdef MCTRL_MEM_TIMEOUT_EN
    begin
      obs_t v;
      for (int unsigned i = 0; i < TO; i++) begin
        opcode = 6'($urandom);
        v = base();
        v.mem_read = 1'b1;
        drive_cycle(1'b0, 1'b0, v, '1);
      end
      fault_m = 1'b1;
      for (int i = 0; i < 5; i++) drive_cycle(rnd_bit(), 1'b0, base(), '1);
      drive_cycle(rnd_bit(), 1'b1, base(), '1);
      count = '0;
      fault_m = 1'b0;
      post_reset();
      run_instr(6'b000000, 6'b100010, 0, 0, -1);
    end
`endif

    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
